// File: rtl/video_capture_core.sv
// Passive capture of a programmable window of one video frame into a local
// pixel buffer, read back by the processor over the video slot bus.
module video_capture_core #(
    parameter int CD         = 12,
    parameter int HMAX       = 640,
    parameter int VMAX       = 480,
    parameter int ADDR_WIDTH = 12
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cs,
    input  logic          write,
    input  logic          read,
    input  logic [13:0]   addr,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data,
    input  logic [CD:0]   tap_data,
    input  logic          tap_valid,
    input  logic          tap_ready,
    output logic          done
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_SOF, S_CAPTURE, S_DONE} state_t;

    state_t                state_q;
    logic [10:0]           origX_q, origY_q, sizeW_q, sizeH_q;
    logic [10:0]           posX_q, posY_q;
    logic [11:0]           winX0_q, winY0_q, winX1_q, winY1_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  err_q, done_q, wrEn_q;
    logic [ADDR_WIDTH-1:0] wrAddr_q;
    logic [CD-1:0]         wrPix_q;
    logic [31:0]           rdData_q;
    logic [CD-1:0]         mem_q [DEPTH];

    logic          beat, sof, regWrite, ctrlWrite, armReq, abortReq;
    logic          busy, inWin, lineEnd, lastPix, captureBeat;
    logic [10:0]   curX, curY;
    logic [CD-1:0] pix;
    logic          unusedOk;

    assign beat      = tap_valid & tap_ready;
    assign sof       = tap_data[0];
    assign pix       = tap_data[CD:1];
    assign regWrite  = cs & write & ~addr[13];
    assign ctrlWrite = regWrite & (addr[1:0] == 2'd0);
    assign abortReq  = ctrlWrite & wr_data[1];
    assign armReq    = ctrlWrite & wr_data[0] & ~wr_data[1];
    assign busy      = (state_q == S_WAIT_SOF) || (state_q == S_CAPTURE);

    // The frame-start beat accepted in WAIT_SOF is pixel (0,0) by definition.
    assign curX = (state_q == S_CAPTURE) ? posX_q : 11'd0;
    assign curY = (state_q == S_CAPTURE) ? posY_q : 11'd0;

    assign inWin = ({1'b0, curX} >= winX0_q) && ({1'b0, curX} < winX1_q) &&
                   ({1'b0, curY} >= winY0_q) && ({1'b0, curY} < winY1_q);
    assign lineEnd     = (curX == 11'(HMAX - 1));
    assign lastPix     = lineEnd && (curY == 11'(VMAX - 1));
    assign captureBeat = beat && (((state_q == S_WAIT_SOF) && sof) ||
                                  ((state_q == S_CAPTURE) && !sof));

    assign unusedOk = ^{addr, wr_data};
    assign rd_data  = rdData_q;
    assign done     = done_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            origX_q  <= '0;
            origY_q  <= '0;
            sizeW_q  <= '0;
            sizeH_q  <= '0;
            posX_q   <= '0;
            posY_q   <= '0;
            winX0_q  <= '0;
            winY0_q  <= '0;
            winX1_q  <= '0;
            winY1_q  <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            wrEn_q   <= 1'b0;
            wrAddr_q <= '0;
            wrPix_q  <= '0;
            rdData_q <= '0;
        end else begin
            wrEn_q <= 1'b0;

            if (regWrite && (addr[1:0] == 2'd1)) begin
                origX_q <= wr_data[10:0];
                origY_q <= wr_data[26:16];
            end
            if (regWrite && (addr[1:0] == 2'd2)) begin
                sizeW_q <= wr_data[10:0];
                sizeH_q <= wr_data[26:16];
            end

            if (cs && read) begin
                if (addr[13]) begin
                    rdData_q <= 32'(mem_q[addr[ADDR_WIDTH-1:0]]);
                end else begin
                    case (addr[1:0])
                        2'd0:    rdData_q <= {29'd0, err_q, busy, done_q};
                        2'd1:    rdData_q <= 32'(count_q);
                        2'd2:    rdData_q <= {5'd0, sizeH_q, 5'd0, sizeW_q};
                        default: rdData_q <= '0;
                    endcase
                end
            end

            if (abortReq) begin
                state_q <= S_IDLE;
                done_q  <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (armReq) begin
                            state_q <= S_WAIT_SOF;
                            done_q  <= 1'b0;
                            err_q   <= 1'b0;
                            count_q <= '0;
                            // Window end is kept as a 12-bit sum so it never wraps.
                            winX0_q <= {1'b0, origX_q};
                            winY0_q <= {1'b0, origY_q};
                            winX1_q <= {1'b0, origX_q} + {1'b0, sizeW_q};
                            winY1_q <= {1'b0, origY_q} + {1'b0, sizeH_q};
                        end
                    end
                    S_WAIT_SOF, S_CAPTURE: begin
                        if (beat && sof && (state_q == S_CAPTURE)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (captureBeat) begin
                            if (inWin) begin
                                if (count_q != FULL) begin
                                    wrEn_q   <= 1'b1;
                                    wrAddr_q <= count_q[ADDR_WIDTH-1:0];
                                    wrPix_q  <= pix;
                                    count_q  <= count_q + 1'b1;
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end
                            if (lastPix) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_CAPTURE;
                                posX_q  <= lineEnd ? 11'd0 : curX + 11'd1;
                                posY_q  <= lineEnd ? curY + 11'd1 : curY;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Buffer write lags the accepted beat by one cycle.
    always_ff @(posedge clk) begin
        if (wrEn_q) begin
            mem_q[wrAddr_q] <= wrPix_q;
        end
    end

endmodule

// File: tb/tb_video_capture_core.sv
// Scoreboard bench for video_capture_core: random frames on a reduced raster,
// expected readback computed from the window geometry of each frame.
module tb_video_capture_core;
    localparam int CD    = 12;
    localparam int HMAX  = 32;
    localparam int VMAX  = 24;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;
    localparam logic [13:0] BUF = 14'h2000;

    logic        clk = 1'b0;
    logic        reset_n, cs, write, read;
    logic [13:0] addr;
    logic [31:0] wr_data, rd_data;
    logic [CD:0] tap_data;
    logic        tap_valid, tap_ready, done;

    always #5 clk = ~clk;

    video_capture_core #(.CD(CD), .HMAX(HMAX), .VMAX(VMAX), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n), .cs(cs), .write(write), .read(read),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .tap_data(tap_data), .tap_valid(tap_valid), .tap_ready(tap_ready),
        .done(done)
    );

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] expQ[$];
    string       tagQ[$];
    logic        readSeen = 1'b0;
    logic [31:0] lastRead = '0;
    bit          gapMode  = 1'b0;

    logic [CD-1:0] frame  [VMAX][HMAX];
    logic [CD-1:0] expBuf [DEPTH];
    int            expCount;
    bit            expErr;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Monitor: a read captured on a rising edge presents rd_data one cycle later.
    always @(posedge clk) readSeen <= cs & read;
    always @(negedge clk) begin
        if (readSeen) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpectedRead: got 0x%08h, expected no read", rd_data);
            end else begin
                checkOutput(tagQ.pop_front(), rd_data, expQ.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [13:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        tick();
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic busRead(input logic [13:0] a, input logic [31:0] e, input string tag);
        cs = 1'b1; read = 1'b1; addr = a;
        expQ.push_back(e);
        tagQ.push_back(tag);
        lastRead = e;
        tick();
        cs = 1'b0; read = 1'b0;
    endtask

    // Non-beat cycles carry random payload, including stray frame-start bits.
    task automatic driveBeat(input logic [CD-1:0] p, input bit s);
        while (gapMode && ($urandom_range(1, 0) == 1)) begin
            case ($urandom_range(2, 0))
                0:       begin tap_valid = 1'b1; tap_ready = 1'b0; end
                1:       begin tap_valid = 1'b0; tap_ready = 1'b1; end
                default: begin tap_valid = 1'b0; tap_ready = 1'b0; end
            endcase
            tap_data = (CD + 1)'($urandom);
            tick();
        end
        tap_valid = 1'b1; tap_ready = 1'b1; tap_data = {p, s};
        tick();
        tap_valid = 1'b0; tap_ready = 1'b0;
    endtask

    task automatic newFrame(input bit ramp);
        for (int y = 0; y < VMAX; y++)
            for (int x = 0; x < HMAX; x++)
                frame[y][x] = ramp ? CD'(x + 16 * y) : CD'($urandom);
    endtask

    task automatic sendRows(input int fromRow, input int toRow, input bit expectCapture);
        for (int y = fromRow; y < toRow; y++) begin
            for (int x = 0; x < HMAX; x++) begin
                bit last = (y == VMAX - 1) && (x == HMAX - 1);
                if (last && expectCapture) checkOutput("doneBeforeLast", 32'(done), 32'd0);
                driveBeat(frame[y][x], (x == 0) && (y == 0));
                if (last && expectCapture) checkOutput("doneAfterLast", 32'(done), 32'd1);
            end
        end
    endtask

    // Rows below 'rows' are the ones delivered before the frame ended.
    task automatic modelCapture(input int x0, input int y0, input int w, input int h,
                                input int rows);
        int n = 0;
        for (int y = y0; (y < y0 + h) && (y < rows); y++)
            for (int x = x0; (x < x0 + w) && (x < HMAX); x++) begin
                if (n < DEPTH) expBuf[n] = frame[y][x];
                n++;
            end
        expCount = (n < DEPTH) ? n : DEPTH;
        expErr   = (n > DEPTH);
    endtask

    task automatic applyStimulus(input int x0, input int y0, input int w, input int h);
        busWrite(14'd1, {5'd0, 11'(y0), 5'd0, 11'(x0)});
        busWrite(14'd2, {5'd0, 11'(h), 5'd0, 11'(w)});
        busWrite(14'd0, 32'd1);
    endtask

    task automatic readBuf(input int i);
        busRead(BUF | 14'(i), 32'(expBuf[i]), $sformatf("buf[%0d]", i));
    endtask

    task automatic checkCapture(input bit shortErr);
        bit e = expErr | shortErr;
        busRead(14'd0, {29'd0, e, 1'b0, 1'b1}, "status");
        busRead(14'd1, 32'(expCount), "count");
        if (expCount == 0) begin
            for (int i = 0; i < 6; i++) readBuf(i);
        end else if (expCount <= 16) begin
            for (int i = 0; i < expCount; i++) readBuf(i);
        end else begin
            readBuf(0);
            readBuf(1);
            readBuf(expCount - 1);
            for (int k = 0; k < 5; k++) readBuf(int'($urandom_range(expCount - 1, 0)));
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0; cs = 1'b0; write = 1'b0; read = 1'b0;
        addr = '0; wr_data = '0; tap_data = '0; tap_valid = 1'b0; tap_ready = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        checkOutput("rstRdData", rd_data, 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        busRead(14'd0, 32'd0, "rstStatus");
        busRead(14'd1, 32'd0, "rstCount");
        busRead(14'd2, 32'd0, "rstSize");

        $display("[TB] ramp frame, window 4x2 at origin");
        newFrame(1'b1);
        busWrite(14'd1, 32'd0);
        busWrite(14'd2, {5'd0, 11'd2, 5'd0, 11'd4});
        busRead(14'd2, 32'h0002_0004, "sizeReadback");
        tap_valid = 1'b1; tap_ready = 1'b1; tap_data = {12'hABC, 1'b1};
        busWrite(14'd0, 32'd1);
        tap_valid = 1'b0; tap_ready = 1'b0;
        for (int k = 0; k < 5; k++) driveBeat(CD'($urandom), 1'b0);
        busRead(14'd0, 32'd2, "statusBusy");
        modelCapture(0, 0, 4, 2, VMAX);
        sendRows(0, VMAX, 1'b1);
        checkCapture(1'b0);

        $display("[TB] window clipped at bottom-right corner");
        newFrame(1'b0);
        applyStimulus(HMAX - 4, VMAX - 2, 8, 8);
        busWrite(14'd1, {5'd0, 11'd3, 5'd0, 11'd1});
        busWrite(14'd2, 32'h0001_0001);
        modelCapture(HMAX - 4, VMAX - 2, 8, 8, VMAX);
        sendRows(0, VMAX, 1'b1);
        checkCapture(1'b0);
        busRead(14'd2, 32'h0001_0001, "sizeShadowed");

        $display("[TB] overflow window 20x20");
        newFrame(1'b0);
        applyStimulus(2, 3, 20, 20);
        modelCapture(2, 3, 20, 20, VMAX);
        sendRows(0, VMAX, 1'b1);
        checkCapture(1'b0);

        $display("[TB] arm mid-frame, gapped stream");
        newFrame(1'b0);
        sendRows(0, 10, 1'b0);
        applyStimulus(5, 7, 6, 3);
        sendRows(10, VMAX, 1'b0);
        newFrame(1'b0);
        modelCapture(5, 7, 6, 3, VMAX);
        gapMode = 1'b1;
        sendRows(0, VMAX, 1'b1);
        gapMode = 1'b0;
        checkCapture(1'b0);

        $display("[TB] short frame, then abort and zero-width capture");
        newFrame(1'b0);
        applyStimulus(0, 8, 3, 4);
        modelCapture(0, 8, 3, 4, 10);
        sendRows(0, 10, 1'b0);
        driveBeat(frame[10][0], 1'b1);
        checkOutput("doneShort", 32'(done), 32'd1);
        checkCapture(1'b1);
        busWrite(14'd0, 32'd3);
        checkOutput("doneAbort", 32'(done), 32'd0);
        busRead(14'd0, 32'd0, "statusAbort");
        newFrame(1'b0);
        applyStimulus(10, 12, 0, 5);
        modelCapture(10, 12, 0, 5, VMAX);
        sendRows(0, VMAX, 1'b1);
        checkCapture(1'b0);

        $display("[TB] reset during capture");
        newFrame(1'b0);
        applyStimulus(1, 20, 5, 2);
        sendRows(0, 12, 1'b0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checkOutput("rdDataAfterReset", rd_data, 32'd0);
        checkOutput("doneAfterReset", 32'(done), 32'd0);
        busRead(14'd0, 32'd0, "statusAfterReset");
        busRead(14'd1, 32'd0, "countAfterReset");
        busRead(14'd2, 32'd0, "sizeAfterReset");
        sendRows(12, VMAX, 1'b0);
        for (int i = 0; i < 6; i++) readBuf(i);

        repeat (4) tick();
        checkOutput("rdHold", rd_data, lastRead);
        if (expQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL pendingReads: got %0d outstanding, expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
